// File: rtl/binario_bcd_seq.sv
// Sequential binary-to-packed-BCD converter (double dabble, one iteration per clock).
// Optional macro SUPRIME_ZEROS_EN: leading-zero blanking (nibble 4'hF) at the result load.
module binario_bcd_seq #(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inicio,
    input  logic [BIN_W-1:0] binario,
    output logic [15:0]      registrador,
    output logic             ocupado,
    output logic             pronto,
    output logic             overflow
);

    localparam int CNT_W = 4;

    typedef enum logic {IDLE, CONV} estadoT;

    estadoT             estado, estadoNext;
    logic [BIN_W-1:0]   shiftBin, shiftBinNext;
    logic [15:0]        bcdAcc, bcdAccNext;
    logic [CNT_W-1:0]   contador, contadorNext;
    logic               ovfFlag, ovfFlagNext;
    logic [15:0]        registradorNext;
    logic               ocupadoNext, prontoNext, overflowNext;
    logic [15:0]        bcdAdj, bcdShift;
    logic               binAcimaLimite;

    function automatic logic [15:0] soma3(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < 4; i++)
            if (v[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = v[i*4 +: 4] + 4'd3;
        return r;
    endfunction

    function automatic logic [15:0] formata(input logic [15:0] v);
        logic [15:0] r;
`ifdef SUPRIME_ZEROS_EN
        logic lider;
        r     = v;
        lider = 1'b1;
        // Units digit is never blanked, so the scan stops at the tens digit.
        for (int i = 3; i >= 1; i--) begin
            if (lider && (v[i*4 +: 4] == 4'd0)) r[i*4 +: 4] = 4'hF;
            else                                lider = 1'b0;
        end
`else
        r = v;
`endif
        return r;
    endfunction

    assign binAcimaLimite = ({{(32-BIN_W){1'b0}}, binario} > 32'd9999);

    always_comb begin
        bcdAdj          = soma3(bcdAcc);
        bcdShift        = {bcdAdj[14:0], shiftBin[BIN_W-1]};
        estadoNext      = estado;
        shiftBinNext    = shiftBin;
        bcdAccNext      = bcdAcc;
        contadorNext    = contador;
        ovfFlagNext     = ovfFlag;
        registradorNext = registrador;
        ocupadoNext     = ocupado;
        overflowNext    = overflow;
        prontoNext      = 1'b0;
        case (estado)
            IDLE: begin
                if (inicio) begin
                    shiftBinNext = binario;
                    bcdAccNext   = 16'h0000;
                    contadorNext = '0;
                    ovfFlagNext  = binAcimaLimite;
                    ocupadoNext  = 1'b1;
                    estadoNext   = CONV;
                end
            end
            CONV: begin
                shiftBinNext = {shiftBin[BIN_W-2:0], 1'b0};
                bcdAccNext   = bcdShift;
                contadorNext = contador + 1'b1;
                if (contador == CNT_W'(BIN_W-1)) begin
                    registradorNext = ovfFlag ? 16'hFFFF : formata(bcdShift);
                    overflowNext    = ovfFlag;
                    prontoNext      = 1'b1;
                    ocupadoNext     = 1'b0;
                    estadoNext      = IDLE;
                end
            end
            default: estadoNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado      <= IDLE;
            shiftBin    <= '0;
            bcdAcc      <= 16'h0000;
            contador    <= '0;
            ovfFlag     <= 1'b0;
            registrador <= 16'h0000;
            ocupado     <= 1'b0;
            pronto      <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            estado      <= estadoNext;
            shiftBin    <= shiftBinNext;
            bcdAcc      <= bcdAccNext;
            contador    <= contadorNext;
            ovfFlag     <= ovfFlagNext;
            registrador <= registradorNext;
            ocupado     <= ocupadoNext;
            pronto      <= prontoNext;
            overflow    <= overflowNext;
        end
    end

endmodule

// File: tb/tb_binario_bcd_seq.sv
// Directed bench for binario_bcd_seq: vector table plus ignore/reset corner sequences.
module tb_binario_bcd_seq;

    localparam int BIN_W = 14;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             inicio = 1'b0;
    logic [BIN_W-1:0] binario = '0;
    logic [15:0]      registrador;
    logic             ocupado, pronto, overflow;

    int checks = 0;
    int errs   = 0;
    logic [15:0] prevReg;

    typedef struct {
        logic [13:0] bin;
        logic [15:0] expPlain;
        logic [15:0] expSup;
        logic        expOvf;
    } vecT;

    vecT vecs[10];

    binario_bcd_seq #(.BIN_W(BIN_W)) dut (
        .clk(clk), .rst_n(rst_n), .inicio(inicio), .binario(binario),
        .registrador(registrador), .ocupado(ocupado), .pronto(pronto), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nome, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", nome, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] esperado(input vecT v);
`ifdef SUPRIME_ZEROS_EN
        return v.expSup;
`else
        return v.expPlain;
`endif
    endfunction

    // Drives inicio now (current cycle), so calling it right after a pronto check starts back-to-back.
    task automatic iniciar(input logic [13:0] v);
        inicio  = 1'b1;
        binario = v;
        @(posedge clk); #1;
        inicio = 1'b0;
        chk("ocupado after accept", {15'b0, ocupado}, 16'h0001);
    endtask

    // Called right after the accept edge; checks busy window and the pronto cycle.
    task automatic concluir(input string nome, input logic [15:0] expReg, input logic expOvf);
        logic busyOk;
        busyOk = 1'b1;
        for (int k = 1; k <= BIN_W-1; k++) begin
            @(posedge clk); #1;
            if (!ocupado || pronto || registrador !== prevReg) busyOk = 1'b0;
        end
        chk({nome, " busy window"}, {15'b0, busyOk}, 16'h0001);
        @(posedge clk); #1;
        chk({nome, " pronto"}, {15'b0, pronto}, 16'h0001);
        chk({nome, " registrador"}, registrador, expReg);
        chk({nome, " overflow"}, {15'b0, overflow}, {15'b0, expOvf});
        chk({nome, " ocupado done"}, {15'b0, ocupado}, 16'h0000);
        prevReg = expReg;
    endtask

    initial begin
        vecs[0] = '{14'd0,     16'h0000, 16'hFFF0, 1'b0};
        vecs[1] = '{14'd1234,  16'h1234, 16'h1234, 1'b0};
        vecs[2] = '{14'd9999,  16'h9999, 16'h9999, 1'b0};
        vecs[3] = '{14'd10000, 16'hFFFF, 16'hFFFF, 1'b1};
        vecs[4] = '{14'd16383, 16'hFFFF, 16'hFFFF, 1'b1};
        vecs[5] = '{14'd7,     16'h0007, 16'hFFF7, 1'b0};
        vecs[6] = '{14'd42,    16'h0042, 16'hFF42, 1'b0};
        vecs[7] = '{14'd1005,  16'h1005, 16'h1005, 1'b0};
        vecs[8] = '{14'd90,    16'h0090, 16'hFF90, 1'b0};
        vecs[9] = '{14'd600,   16'h0600, 16'hF600, 1'b0};

        #12;
        chk("reset registrador", registrador, 16'h0000);
        chk("reset ocupado", {15'b0, ocupado}, 16'h0000);
        chk("reset pronto", {15'b0, pronto}, 16'h0000);
        chk("reset overflow", {15'b0, overflow}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        prevReg = 16'h0000;
        @(negedge clk);

        // Back-to-back: each next inicio is raised in the previous pronto cycle.
        for (int i = 0; i < 10; i++) begin
            iniciar(vecs[i].bin);
            concluir($sformatf("vec%0d", i), esperado(vecs[i]), vecs[i].expOvf);
        end
        @(posedge clk); #1;
        chk("pronto single pulse", {15'b0, pronto}, 16'h0000);

        // inicio and binario change mid-conversion are ignored.
        @(negedge clk);
        inicio = 1'b1; binario = 14'd4321;
        @(posedge clk); #1;
        inicio = 1'b0;
        begin
            logic ok;
            ok = 1'b1;
            for (int k = 1; k <= BIN_W-1; k++) begin
                if (k == 5) begin inicio = 1'b1; binario = 14'd55; end
                else if (k == 6) inicio = 1'b0;
                @(posedge clk); #1;
                if (!ocupado || pronto) ok = 1'b0;
            end
            chk("ignore busy window", {15'b0, ok}, 16'h0001);
            @(posedge clk); #1;
            chk("ignore pronto", {15'b0, pronto}, 16'h0001);
            chk("ignore registrador", registrador, 16'h4321);
            chk("ignore overflow", {15'b0, overflow}, 16'h0000);
            ok = 1'b1;
            for (int k = 0; k < 20; k++) begin
                @(posedge clk); #1;
                if (pronto || ocupado) ok = 1'b0;
            end
            chk("ignore no extra pronto", {15'b0, ok}, 16'h0001);
        end

        // Reset abort mid-conversion.
        @(negedge clk);
        inicio = 1'b1; binario = 14'd8765;
        @(posedge clk); #1;
        inicio = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort registrador", registrador, 16'h0000);
        chk("abort ocupado", {15'b0, ocupado}, 16'h0000);
        chk("abort pronto", {15'b0, pronto}, 16'h0000);
        chk("abort overflow", {15'b0, overflow}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            logic ok;
            ok = 1'b1;
            for (int k = 0; k < 20; k++) begin
                @(posedge clk); #1;
                if (pronto || ocupado) ok = 1'b0;
            end
            chk("abort no pronto", {15'b0, ok}, 16'h0001);
        end
        prevReg = 16'h0000;
        @(negedge clk);
        iniciar(14'd8765);
        concluir("after abort", 16'h8765, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end

endmodule
